// File: rtl/pipeline_pkg.sv
// pipeline_pkg: definitions shared across the 5-stage core pipeline.
//   - Instruction field bit positions (opcode/rd/rs/rt upper bits).
//   - NOP_INSN: instruction word used for pipeline bubbles.
//   - fetch_state_e: fetch-stage FSM encoding.
//   - fd_sel_e: what the F/D register loads in a given cycle.
//   - sat_inc32: saturating increment for 32-bit event counters.
package pipeline_pkg;

    localparam int unsigned OP_HI = 31;
    localparam int unsigned RD_HI = 26;
    localparam int unsigned RS_HI = 21;
    localparam int unsigned RT_HI = 16;

    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StDrain = 2'd2,
        StHold  = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        FdKeep   = 2'd0,
        FdBubble = 2'd1,
        FdMem    = 2'd2,
        FdHold   = 2'd3
    } fd_sel_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/fd_hold_buf.sv
// fd_hold_buf: one-entry buffer of {insn, pc} with a valid flag.
// Parks an instruction that arrived from memory while decode was stalled.
// Ports:
//   clock, reset_n      clock and asynchronous active-low reset
//   load                capture load_insn/load_pc and set valid (wins over clear)
//   clear               drop the entry
//   load_insn, load_pc  data to capture
//   insn, pc, valid     buffered entry
module fd_hold_buf #(
    parameter int unsigned PC_W = 12
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            load,
    input  logic            clear,
    input  logic [31:0]     load_insn,
    input  logic [PC_W-1:0] load_pc,
    output logic [31:0]     insn,
    output logic [PC_W-1:0] pc,
    output logic            valid
);
    import pipeline_pkg::*;

    logic [31:0]     insn_q;
    logic [PC_W-1:0] pc_q;
    logic            valid_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            insn_q  <= NOP_INSN;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            insn_q  <= load_insn;
            pc_q    <= load_pc;
            valid_q <= 1'b1;
        end else if (clear) begin
            valid_q <= 1'b0;
        end
    end

    assign insn  = insn_q;
    assign pc    = pc_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch and F/D pipeline register.
// Owns the PC, fetches over a req/valid handshake, and presents instructions
// to decode. Redirects from execute flush F/D; load-use stalls freeze F/D.
// Optional macro FETCH_PERF_EN adds saturating perf counters and their ports.
// Ports:
//   clock, reset_n              clock and asynchronous active-low reset
//   stall                       hold PC and F/D (load-use hazard)
//   redirect_valid/redirect_pc  taken branch/jump target (word address)
//   imem_req/imem_addr          fetch request; address stable until imem_valid
//   imem_rdata/imem_valid       memory response for imem_addr
//   fd_insn/fd_pc/fd_valid      F/D register contents
//   perf_fetched/perf_stall/perf_bubble (FETCH_PERF_EN only) event counters
module fetch_stage #(
    parameter int unsigned     PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_INSN = pipeline_pkg::NOP_INSN
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    output logic [31:0]     fd_insn,
    output logic [PC_W-1:0] fd_pc,
    output logic            fd_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall,
    output logic [31:0]     perf_bubble
`endif
);
    import pipeline_pkg::*;

    fetch_state_e    state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] req_addr_q;
    logic [PC_W-1:0] pc_inc;
    logic [31:0]     fd_insn_q;
    logic [PC_W-1:0] fd_pc_q;
    logic            fd_valid_q;

    fd_sel_e         fd_sel;
    logic            hold_load;
    logic            hold_clear;
    logic [31:0]     hold_insn;
    logic [PC_W-1:0] hold_pc;
    logic            hold_valid;

    // Wraps modulo 2^PC_W.
    assign pc_inc = pc_q + PC_W'(1);

    // F/D source: redirect flushes, stall freezes, otherwise the state decides.
    always_comb begin
        fd_sel = FdBubble;
        if (redirect_valid) begin
            fd_sel = FdBubble;
        end else if (stall) begin
            fd_sel = FdKeep;
        end else begin
            case (state_q)
                StReq:   fd_sel = imem_valid ? FdMem : FdBubble;
                StHold:  fd_sel = hold_valid ? FdHold : FdBubble;
                default: fd_sel = FdBubble;
            endcase
        end
    end

    // A word that lands during a stall is parked so the request slot frees up.
    assign hold_load  = (state_q == StReq) && imem_valid && !redirect_valid && stall;
    assign hold_clear = (state_q == StHold) && (redirect_valid || !stall);

    fd_hold_buf #(
        .PC_W(PC_W)
    ) u_hold_buf (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (hold_load),
        .clear    (hold_clear),
        .load_insn(imem_rdata),
        .load_pc  (req_addr_q),
        .insn     (hold_insn),
        .pc       (hold_pc),
        .valid    (hold_valid)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            fd_insn_q  <= NOP_INSN;
            fd_pc_q    <= '0;
            fd_valid_q <= 1'b0;
        end else begin
            case (fd_sel)
                FdBubble: begin
                    fd_insn_q  <= NOP_INSN;
                    fd_valid_q <= 1'b0;
                end
                FdMem: begin
                    fd_insn_q  <= imem_rdata;
                    fd_pc_q    <= req_addr_q;
                    fd_valid_q <= 1'b1;
                end
                FdHold: begin
                    fd_insn_q  <= hold_insn;
                    fd_pc_q    <= hold_pc;
                    fd_valid_q <= 1'b1;
                end
                default: ;
            endcase

            case (state_q)
                StIdle: begin
                    if (redirect_valid) begin
                        pc_q       <= redirect_pc;
                        req_addr_q <= redirect_pc;
                    end else begin
                        req_addr_q <= pc_q;
                    end
                    state_q <= StReq;
                end
                StReq: begin
                    if (imem_valid) begin
                        if (redirect_valid) begin
                            pc_q       <= redirect_pc;
                            req_addr_q <= redirect_pc;
                        end else begin
                            pc_q       <= pc_inc;
                            req_addr_q <= pc_inc;
                            if (stall) begin
                                state_q <= StHold;
                            end
                        end
                    end else if (redirect_valid) begin
                        // Outstanding request must finish on its old address.
                        pc_q    <= redirect_pc;
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (imem_valid) begin
                        req_addr_q <= redirect_valid ? redirect_pc : pc_q;
                        state_q    <= StReq;
                    end
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                    end
                end
                StHold: begin
                    if (redirect_valid) begin
                        pc_q       <= redirect_pc;
                        req_addr_q <= redirect_pc;
                        state_q    <= StReq;
                    end else if (!stall) begin
                        state_q <= StReq;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign imem_req  = (state_q == StReq) || (state_q == StDrain);
    assign imem_addr = req_addr_q;
    assign fd_insn   = fd_insn_q;
    assign fd_pc     = fd_pc_q;
    assign fd_valid  = fd_valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_bubble_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
            perf_bubble_q  <= '0;
        end else begin
            if ((fd_sel == FdMem) || (fd_sel == FdHold)) begin
                perf_fetched_q <= sat_inc32(perf_fetched_q);
            end
            if (stall) begin
                perf_stall_q <= sat_inc32(perf_stall_q);
            end
            if (fd_sel == FdBubble) begin
                perf_bubble_q <= sat_inc32(perf_bubble_q);
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
    assign perf_bubble  = perf_bubble_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run checked
// against a program-order stream model (in-order PCs, redirect targets,
// stall freeze, address stability).
module tb_fetch_stage;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] fd_insn;
    logic [11:0] fd_pc;
    logic        fd_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] perf_bubble;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    fetch_stage #(
        .PC_W    (12),
        .RESET_PC(12'h000),
        .NOP_INSN(32'h0000_0000)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .fd_insn       (fd_insn),
        .fd_pc         (fd_pc),
        .fd_valid      (fd_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall),
        .perf_bubble   (perf_bubble)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: responds wait_cnt cycles after a request starts.
    bit          mem_rand = 1'b0;
    int unsigned mem_lat  = 0;
    int unsigned wait_cnt;

    function automatic int unsigned pick_lat();
        return mem_rand ? $urandom_range(3, 0) : mem_lat;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= pick_lat();
        end else if (imem_req) begin
            if (wait_cnt == 0) wait_cnt <= pick_lat();
            else               wait_cnt <= wait_cnt - 1;
        end
    end

    assign imem_valid = imem_req && (wait_cnt == 0);
    assign imem_rdata = 32'h100 + {20'd0, imem_addr};

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 12'h000;
        reset_n        = 1'b0;
        #12;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 12'h000;
        reset_n        = 1'b0;
        #1;
        n_checks++;
        if (fd_insn !== 32'h0) $display("FAIL reset_fd_insn got %h want 00000000", fd_insn);
        else n_pass++;
        n_checks++;
        if (fd_pc !== 12'h0) $display("FAIL reset_fd_pc got %h want 000", fd_pc);
        else n_pass++;
        n_checks++;
        if (fd_valid !== 1'b0) $display("FAIL reset_fd_valid got %b want 0", fd_valid);
        else n_pass++;
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL reset_imem_req got %b want 0", imem_req);
        else n_pass++;
        n_checks++;
        if (imem_addr !== 12'h0) $display("FAIL reset_imem_addr got %h want 000", imem_addr);
        else n_pass++;
    endtask

    task automatic test_straight_line();
        int n = 0;
        mem_rand = 1'b0;
        mem_lat  = 0;
        do_reset();
        while (fd_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (fd_valid !== 1'b1 || fd_pc !== 12'(i) || fd_insn !== 32'h100 + 32'(i))
                $display("FAIL straight_%0d got valid=%b pc=%h insn=%h want valid=1 pc=%h insn=%h",
                         i, fd_valid, fd_pc, fd_insn, 12'(i), 32'h100 + 32'(i));
            else n_pass++;
            step();
        end
    endtask

    task automatic test_latency();
        int n = 0;
        mem_rand = 1'b0;
        mem_lat  = 1;
        do_reset();
        while (imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (imem_addr !== 12'(k) || imem_valid !== 1'b0)
                $display("FAIL lat_req_%0d got addr=%h valid=%b want addr=%h valid=0",
                         k, imem_addr, imem_valid, 12'(k));
            else n_pass++;
            step();
            n_checks++;
            if (imem_addr !== 12'(k) || imem_valid !== 1'b1 || fd_valid !== 1'b0)
                $display("FAIL lat_wait_%0d got addr=%h valid=%b fd_valid=%b want addr=%h 1 0",
                         k, imem_addr, imem_valid, fd_valid, 12'(k));
            else n_pass++;
            step();
            n_checks++;
            if (fd_valid !== 1'b1 || fd_pc !== 12'(k))
                $display("FAIL lat_insn_%0d got fd_valid=%b fd_pc=%h want 1 %h",
                         k, fd_valid, fd_pc, 12'(k));
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        int n = 0;
        logic [31:0] s_insn;
        logic [11:0] s_pc;
        mem_rand = 1'b0;
        mem_lat  = 0;
        do_reset();
        while (!(fd_valid === 1'b1 && fd_pc === 12'h003) && n < 30) begin
            step();
            n++;
        end
        s_insn = fd_insn;
        s_pc   = fd_pc;
        stall  = 1'b1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_valid !== 1'b1)
            $display("FAIL stall_resp_c1 got req=%b valid=%b want 1 1", imem_req, imem_valid);
        else n_pass++;
        for (int c = 2; c <= 4; c++) begin
            step();
            n_checks++;
            if (fd_insn !== s_insn || fd_pc !== s_pc || fd_valid !== 1'b1)
                $display("FAIL stall_frozen_c%0d got pc=%h insn=%h valid=%b want pc=%h insn=%h 1",
                         c, fd_pc, fd_insn, fd_valid, s_pc, s_insn);
            else n_pass++;
            if (c <= 3) begin
                n_checks++;
                if (imem_req !== 1'b0) $display("FAIL stall_req_c%0d got %b want 0", c, imem_req);
                else n_pass++;
            end
        end
        stall = 1'b0;
        step();
        n_checks++;
        if (fd_valid !== 1'b1 || fd_pc !== 12'h004 || fd_insn !== 32'h104)
            $display("FAIL stall_held_word got valid=%b pc=%h insn=%h want 1 004 00000104",
                     fd_valid, fd_pc, fd_insn);
        else n_pass++;
        step();
        n_checks++;
        if (fd_valid !== 1'b1 || fd_pc !== 12'h005)
            $display("FAIL stall_next_word got valid=%b pc=%h want 1 005", fd_valid, fd_pc);
        else n_pass++;
    endtask

    task automatic test_redirect();
        int n = 0;
        mem_rand = 1'b0;
        mem_lat  = 0;
        do_reset();
        while (imem_addr !== 12'h004 && n < 30) begin
            step();
            n++;
        end
        n_checks++;
        if (imem_addr !== 12'h004) $display("FAIL redir_reach4 got %h want 004", imem_addr);
        else n_pass++;
        mem_lat = 2;
        step();
        n_checks++;
        if (imem_addr !== 12'h005 || imem_valid !== 1'b0)
            $display("FAIL redir_pending got addr=%h valid=%b want 005 0", imem_addr, imem_valid);
        else n_pass++;
        redirect_valid = 1'b1;
        redirect_pc    = 12'h040;
        step();
        redirect_valid = 1'b0;
        mem_lat        = 0;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 12'h005 || fd_valid !== 1'b0)
                $display("FAIL redir_drain_%0d got req=%b addr=%h fd_valid=%b want 1 005 0",
                         c, imem_req, imem_addr, fd_valid);
            else n_pass++;
            step();
        end
        n_checks++;
        if (imem_addr !== 12'h040 || fd_valid !== 1'b0)
            $display("FAIL redir_new_req got addr=%h fd_valid=%b want 040 0", imem_addr, fd_valid);
        else n_pass++;
        step();
        n_checks++;
        if (fd_valid !== 1'b1 || fd_pc !== 12'h040 || fd_insn !== 32'h140)
            $display("FAIL redir_target got valid=%b pc=%h insn=%h want 1 040 00000140",
                     fd_valid, fd_pc, fd_insn);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int n = 0;
        mem_rand = 1'b0;
        mem_lat  = 0;
        do_reset();
        while (fd_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        redirect_valid = 1'b1;
        redirect_pc    = 12'hFFF;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_addr !== 12'hFFF || fd_valid !== 1'b0)
            $display("FAIL wrap_req got addr=%h fd_valid=%b want FFF 0", imem_addr, fd_valid);
        else n_pass++;
        step();
        n_checks++;
        if (fd_valid !== 1'b1 || fd_pc !== 12'hFFF || fd_insn !== 32'h10FF || imem_addr !== 12'h000)
            $display("FAIL wrap_top got valid=%b pc=%h insn=%h addr=%h want 1 FFF 000010FF 000",
                     fd_valid, fd_pc, fd_insn, imem_addr);
        else n_pass++;
        step();
        n_checks++;
        if (fd_valid !== 1'b1 || fd_pc !== 12'h000)
            $display("FAIL wrap_zero got valid=%b pc=%h want 1 000", fd_valid, fd_pc);
        else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        int n = 0;
        mem_rand = 1'b0;
        mem_lat  = 0;
        do_reset();
        while (!(fd_valid === 1'b1 && fd_pc === 12'h003) && n < 30) begin
            step();
            n++;
        end
        mem_lat = 3;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 12'h077;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr === 12'h000)
            $display("FAIL rstdrain_setup got req=%b addr=%h want 1 nonzero", imem_req, imem_addr);
        else n_pass++;
        mem_lat = 0;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || imem_addr !== 12'h000 || fd_valid !== 1'b0 ||
            fd_pc !== 12'h000 || fd_insn !== 32'h0)
            $display("FAIL rstdrain_async got req=%b addr=%h fdv=%b fdpc=%h insn=%h want 0 000 0 000 0",
                     imem_req, imem_addr, fd_valid, fd_pc, fd_insn);
        else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 12'h000)
            $display("FAIL rstdrain_first_req got req=%b addr=%h want 1 000", imem_req, imem_addr);
        else n_pass++;
        step();
        n_checks++;
        if (fd_valid !== 1'b1 || fd_pc !== 12'h000)
            $display("FAIL rstdrain_first_insn got valid=%b pc=%h want 1 000", fd_valid, fd_pc);
        else n_pass++;
    endtask

    // Stream model: valid F/D words appear in program order starting at the
    // reset PC, restart at each redirect target, and freeze while stalled.
    task automatic test_random();
        logic [11:0] exp_pc;
        logic        pre_stall;
        logic        pre_redir;
        logic [11:0] pre_rpc;
        logic [31:0] pre_insn;
        logic [11:0] pre_pc;
        logic        pre_valid;
        logic        pre_wait;
        logic [11:0] pre_addr;
        int          fetched = 0;
        int          errs    = 0;
        mem_rand = 1'b1;
        do_reset();
        exp_pc = 12'h000;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            stall          = ($urandom_range(99, 0) < 25);
            redirect_valid = ($urandom_range(99, 0) < 8);
            redirect_pc    = ($urandom_range(3, 0) == 0) ? 12'hFFC + 12'($urandom_range(3, 0))
                                                         : 12'($urandom);
            pre_stall = stall;
            pre_redir = redirect_valid;
            pre_rpc   = redirect_pc;
            pre_insn  = fd_insn;
            pre_pc    = fd_pc;
            pre_valid = fd_valid;
            pre_wait  = imem_req && !imem_valid;
            pre_addr  = imem_addr;
            step();
            if (pre_redir) begin
                n_checks++;
                if (fd_valid !== 1'b0) begin
                    if (errs < 10) $display("FAIL rand_flush cyc %0d got fd_valid=%b want 0",
                                            cyc, fd_valid);
                    errs++;
                end else n_pass++;
                exp_pc = pre_rpc;
            end else if (pre_stall) begin
                n_checks++;
                if (fd_insn !== pre_insn || fd_pc !== pre_pc || fd_valid !== pre_valid) begin
                    if (errs < 10)
                        $display("FAIL rand_freeze cyc %0d got %h/%h/%b want %h/%h/%b", cyc,
                                 fd_insn, fd_pc, fd_valid, pre_insn, pre_pc, pre_valid);
                    errs++;
                end else n_pass++;
            end else if (fd_valid === 1'b1) begin
                n_checks++;
                if (fd_pc !== exp_pc || fd_insn !== 32'h100 + {20'd0, exp_pc}) begin
                    if (errs < 10)
                        $display("FAIL rand_order cyc %0d got pc=%h insn=%h want pc=%h insn=%h",
                                 cyc, fd_pc, fd_insn, exp_pc, 32'h100 + {20'd0, exp_pc});
                    errs++;
                end else n_pass++;
                exp_pc = exp_pc + 12'd1;
                fetched++;
            end
            if (pre_wait && imem_req === 1'b1) begin
                n_checks++;
                if (imem_addr !== pre_addr) begin
                    if (errs < 10) $display("FAIL rand_addr_stable cyc %0d got %h want %h",
                                            cyc, imem_addr, pre_addr);
                    errs++;
                end else n_pass++;
            end
        end
        stall          = 1'b0;
        redirect_valid = 1'b0;
        n_checks++;
        if (fetched < 100) $display("FAIL rand_progress got %0d want >= 100", fetched);
        else n_pass++;
    endtask

    initial begin
        reset_n        = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 12'h000;
        test_reset();
        test_straight_line();
        test_latency();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_mid_drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
